// File: rtl/addr_adder_pipe.sv
// Pipelined address adder/subtractor. The carry chain is cut into STAGES slices,
// and each slice has its own register stage with valid/ready flow control.
module addr_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // Pipeline state. a_r/bx_r carry the full operands forward so that later
    // slices and the final overflow check can reach them.
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  bx_r  [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic              ovf_r;

    logic [WIDTH-1:0]  bx_in_s;
    logic              cin_eff_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_bx_s  [STAGES];
    logic [WIDTH-1:0]  src_sum_s [STAGES];
    logic [WIDTH-1:0]  sum_nxt_s [STAGES];
    logic [SW:0]       slice_s   [STAGES];
    logic [STAGES-1:0] src_c_s;
    logic [STAGES-1:0] src_v_s;
    logic [STAGES-1:0] carry_nxt_s;
    logic [STAGES-1:0] tail_full_s;
    logic [STAGES-1:0] load_s;
    logic              ovf_nxt_s;

    // Subtract is a + ~b + ~cin, so B and the carry are inverted up front.
    always_comb begin
        if (sub) begin
            bx_in_s   = ~b;
            cin_eff_s = ~cin;
        end else begin
            bx_in_s   = b;
            cin_eff_s = cin;
        end
    end

    // Slice adders: each stage adds its own slice using the carry stored upstream.
    always_comb begin
        src_a_s[0]   = a;
        src_bx_s[0]  = bx_in_s;
        src_sum_s[0] = {WIDTH{1'b0}};
        src_c_s[0]   = cin_eff_s;
        src_v_s[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = a_r[k-1];
            src_bx_s[k]  = bx_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_v_s[k]   = valid_r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_s[k] = {1'b0, src_a_s[k][k*SW +: SW]}
                       + {1'b0, src_bx_s[k][k*SW +: SW]}
                       + {{SW{1'b0}}, src_c_s[k]};
            sum_nxt_s[k] = src_sum_s[k];
            sum_nxt_s[k][k*SW +: SW] = slice_s[k][SW-1:0];
            carry_nxt_s[k] = slice_s[k][SW];
        end
        ovf_nxt_s = (src_a_s[STAGES-1][MSB] == src_bx_s[STAGES-1][MSB]) &&
                    (sum_nxt_s[STAGES-1][MSB] != src_a_s[STAGES-1][MSB]);
    end

    // A stage may load unless it and every stage after it is full while the
    // output is stalled, so empty stages absorb data even under backpressure.
    always_comb begin
        tail_full_s = {STAGES{1'b0}};
        load_s      = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            tail_full_s[k] = &(valid_r | ~({STAGES{1'b1}} << k));
            load_s[k]      = out_ready | ~tail_full_s[k];
        end
    end

    // Stage registers; data only moves when a valid operation arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                bx_r[k]  <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= src_v_s[k];
                    if (src_v_s[k]) begin
                        a_r[k]     <= src_a_s[k];
                        bx_r[k]    <= src_bx_s[k];
                        sum_r[k]   <= sum_nxt_s[k];
                        carry_r[k] <= carry_nxt_s[k];
                    end
                end
            end
            if (load_s[STAGES-1] && src_v_s[STAGES-1]) begin
                ovf_r <= ovf_nxt_s;
            end
        end
    end

    assign in_ready  = load_s[0];
    assign out_valid = valid_r[STAGES-1];
    assign s         = sum_r[STAGES-1];
    assign cout      = carry_r[STAGES-1];
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_addr_adder_pipe.sv
// Directed/self-checking bench for addr_adder_pipe; three configurations
// (32/2, 64/4, 16/1) share one stimulus stream and each keeps its own scoreboard.
module tb_addr_adder_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, sub, cin;
    logic [63:0] a, b;

    logic        rdy0, ov0, c0, o0;
    logic [31:0] s0;
    logic        rdy1, ov1, c1, o1;
    logic [63:0] s1;
    logic        rdy2, ov2, c2, o2;
    logic [15:0] s2;

    always #5 clk = ~clk;

    addr_adder_pipe #(.WIDTH(32), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a(a[31:0]), .b(b[31:0]), .sub(sub), .cin(cin),
        .out_valid(ov0), .out_ready(out_ready), .s(s0), .cout(c0), .ovf(o0));

    addr_adder_pipe #(.WIDTH(64), .STAGES(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(c1), .ovf(o1));

    addr_adder_pipe #(.WIDTH(16), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .cin(cin),
        .out_valid(ov2), .out_ready(out_ready), .s(s2), .cout(c2), .ovf(o2));

    int n_cmp = 0;
    int n_err = 0;
    logic [65:0] q0[$], q1[$], q2[$];
    int acc0 = 0, acc1 = 0, acc2 = 0;
    int pop0 = 0, pop1 = 0, pop2 = 0;
    logic        use_hand;
    logic [33:0] hand;

    task automatic check_eq(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic at width w, returns {ovf, cout, s}.
    function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic sb, input logic ci);
        logic [63:0] mask, xm, ym, sm;
        logic [64:0] full;
        logic        cc, oo;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xm   = x & mask;
        ym   = (sb ? ~y : y) & mask;
        full = {1'b0, xm} + {1'b0, ym} + {64'd0, (sb ? ~ci : ci)};
        sm   = full[63:0] & mask;
        cc   = full[w];
        oo   = (xm[w-1] == ym[w-1]) && (sm[w-1] != xm[w-1]);
        return {oo, cc, sm};
    endfunction

    // Scoreboard: pops for outputs leaving, pushes for inputs entering at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (ov0 && out_ready) begin
                check_eq("dut0 result", {o0, c0, 32'd0, s0}, (q0.size() > 0) ? q0.pop_front() : {66{1'bx}});
                pop0++;
            end
            if (ov1 && out_ready) begin
                check_eq("dut1 result", {o1, c1, s1}, (q1.size() > 0) ? q1.pop_front() : {66{1'bx}});
                pop1++;
            end
            if (ov2 && out_ready) begin
                check_eq("dut2 result", {o2, c2, 48'd0, s2}, (q2.size() > 0) ? q2.pop_front() : {66{1'bx}});
                pop2++;
            end
            if (in_valid && rdy0) begin
                q0.push_back(use_hand ? {hand[33], hand[32], 32'd0, hand[31:0]} : model(32, a, b, sub, cin));
                acc0++;
            end
            if (in_valid && rdy1) begin
                q1.push_back(model(64, a, b, sub, cin));
                acc1++;
            end
            if (in_valid && rdy2) begin
                q2.push_back(model(16, a, b, sub, cin));
                acc2++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic sb, input logic ci,
                        input logic uh, input logic [33:0] h);
        a = x; b = y; sub = sb; cin = ci; use_hand = uh; hand = h;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        use_hand = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q0.size() + q1.size() + q2.size()) != 0; i++) tick();
        check_eq(tag, 66'(q0.size() + q1.size() + q2.size()), 66'd0);
    endtask

    // Hand-computed 32-bit vectors: {ovf, cout, s}.
    logic [63:0] va [8] = '{64'h0000FFFF, 64'hFFFFFFFF, 64'h7FFFFFFF, 64'h00001000,
                            64'h00000000, 64'h00000001, 64'h80000000, 64'h00000005};
    logic [63:0] vb [8] = '{64'h00000001, 64'h00000001, 64'h00000001, 64'h00000004,
                            64'h00000001, 64'h00000001, 64'h00000001, 64'h00000005};
    logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [33:0] vx [8] = '{{2'b00, 32'h00010000}, {2'b01, 32'h00000000},
                            {2'b10, 32'h80000000}, {2'b01, 32'h00000FFB},
                            {2'b00, 32'hFFFFFFFF}, {2'b00, 32'h00000003},
                            {2'b11, 32'h7FFFFFFF}, {2'b00, 32'hFFFFFFFF}};

    initial begin
        int lat0, lat1, lat2, p0, p1, p2, k0, k1, k2;
        logic bad;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 64'd0; b = 64'd0; sub = 1'b0; cin = 1'b0;
        use_hand = 1'b0; hand = 34'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("reset dut0", {rdy0, ov0, c0, o0, s0}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        check_eq("reset dut1", {rdy1, ov1, c1, o1, s1}, {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
        check_eq("reset dut2", {rdy2, ov2, c2, o2, s2}, {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});

        // Latency from an isolated transfer, counted in clock edges.
        send(va[0], vb[0], vs[0], vc[0], 1'b1, vx[0]);
        lat0 = 0; lat1 = 0; lat2 = 0;
        for (int n = 1; n <= 8; n++) begin
            if (ov0 && lat0 == 0) lat0 = n;
            if (ov1 && lat1 == 0) lat1 = n;
            if (ov2 && lat2 == 0) lat2 = n;
            tick();
        end
        check_eq("latency dut0", 66'(lat0), 66'd2);
        check_eq("latency dut1", 66'(lat1), 66'd4);
        check_eq("latency dut2", 66'(lat2), 66'd1);

        for (int i = 1; i < 8; i++) send(va[i], vb[i], vs[i], vc[i], 1'b1, vx[i]);
        drain("directed drain");

        // Back-to-back burst; full throughput means all results out shortly after.
        p0 = pop0; p1 = pop1; p2 = pop2;
        for (int i = 0; i < 16; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0, 34'd0);
        repeat (4) tick();
        check_eq("burst dut0", 66'(pop0 - p0), 66'd16);
        check_eq("burst dut1", 66'(pop1 - p1), 66'd16);
        check_eq("burst dut2", 66'(pop2 - p2), 66'd16);
        drain("burst drain");

        // Backpressure: only STAGES operations fit, outputs hold.
        out_ready = 1'b0;
        k0 = acc0; k1 = acc1; k2 = acc2;
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            sub = 1'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_eq("stall accepted dut0", 66'(acc0 - k0), 66'd2);
        check_eq("stall accepted dut1", 66'(acc1 - k1), 66'd4);
        check_eq("stall accepted dut2", 66'(acc2 - k2), 66'd1);
        check_eq("stall in_ready", {63'd0, rdy0, rdy1, rdy2}, 66'd0);
        repeat (3) tick();
        check_eq("stall hold dut0", {o0, c0, 32'd0, s0}, q0[0]);
        check_eq("stall hold dut1", {o1, c1, s1}, q1[0]);
        check_eq("stall hold dut2", {o2, c2, 48'd0, s2}, q2[0]);
        out_ready = 1'b1;
        drain("stall drain");

        // Reset with operations in flight; input offered during reset is ignored.
        send(64'h0000_0001_2345_6789, 64'h0000_0000_1111_1111, 1'b0, 1'b0, 1'b0, 34'd0);
        send(64'h0000_0000_0000_00AA, 64'h0000_0000_0000_0055, 1'b1, 1'b0, 1'b0, 34'd0);
        rst = 1'b1;
        a = 64'h1234; b = 64'h4321; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("post-reset dut0", {ov0, rdy0, s0}, {1'b0, 1'b1, 32'd0});
        check_eq("post-reset dut1", {ov1, rdy1, s1}, {1'b0, 1'b1, 64'd0});
        check_eq("post-reset dut2", {ov2, rdy2, s2}, {1'b0, 1'b1, 16'd0});
        bad = 1'b0;
        repeat (8) begin
            tick();
            bad = bad | ov0 | ov1 | ov2;
        end
        check_eq("no stale result", {65'd0, bad}, 66'd0);

        // Pipeline still works after reset.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 34'd0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 34'd0);
        send(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 34'd0);
        drain("final drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
